// File: rtl/dma_bank_requester.sv
// dma_bank_requester: single-word-at-a-time copy engine that arbitrates for a
// memory bank on every read and every write, reporting completion with a pulse.
//
// state   | meaning
// IDLE    | waiting for start; SRC/DST/LEN writable
// RD_REQ  | requesting the bank holding the current source word
// RD_DATA | capturing the returned read data into the word buffer
// WR_REQ  | requesting the bank holding the current destination word
// DONE    | one-cycle completion pulse, then back to IDLE
module dma_bank_requester #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_BANKS  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic [NUM_BANKS-1:0]  bank_request,
    input  logic [NUM_BANKS-1:0]  bank_grant,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(16'hFF00);
    localparam logic [ADDR_WIDTH-1:0] A_SRC  = ADDR_WIDTH'(16'hFF01);
    localparam logic [ADDR_WIDTH-1:0] A_DST  = ADDR_WIDTH'(16'hFF02);
    localparam logic [ADDR_WIDTH-1:0] A_LEN  = ADDR_WIDTH'(16'hFF03);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [ADDR_WIDTH-1:0] wsrc_q, wsrc_d, wdst_q, wdst_d, rem_q, rem_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  done_q, done_d;

    logic                  ctrl_wr, start_cmd, abort_cmd, active, granted;
    logic [NUM_BANKS-1:0]  req;
    logic                  unused_cfg;

    function automatic logic [NUM_BANKS-1:0] bank_sel(input logic [ADDR_WIDTH-1:0] a);
        return NUM_BANKS'(1) << a[ADDR_WIDTH-1 -: BANK_W];
    endfunction

    assign ctrl_wr    = cfg_we && (cfg_addr == A_CTRL);
    assign abort_cmd  = ctrl_wr && cfg_wdata[1];
    assign start_cmd  = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
    assign active     = (state_q == S_RD_REQ) || (state_q == S_RD_DATA) || (state_q == S_WR_REQ);
    assign unused_cfg = ^cfg_wdata;

    // Request is decoded from registered state only, so grant never reaches an output.
    always_comb begin
        req = '0;
        if (state_q == S_RD_REQ) begin
            req = bank_sel(wsrc_q);
        end else if (state_q == S_WR_REQ) begin
            req = bank_sel(wdst_q);
        end
    end

    assign granted = |(req & bank_grant);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        wsrc_d  = wsrc_q;
        wdst_d  = wdst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    if (cfg_addr == A_SRC) src_d = cfg_wdata[ADDR_WIDTH-1:0];
                    if (cfg_addr == A_DST) dst_d = cfg_wdata[ADDR_WIDTH-1:0];
                    if (cfg_addr == A_LEN) len_d = cfg_wdata[ADDR_WIDTH-1:0];
                end
                if (start_cmd) begin
                    if (len_q != '0) begin
                        wsrc_d  = src_q;
                        wdst_d  = dst_q;
                        rem_d   = len_q;
                        state_d = S_RD_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                if (granted) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                buf_d   = mem_rdata;
                state_d = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (granted) begin
                    wsrc_d = wsrc_q + ADDR_WIDTH'(1);
                    wdst_d = wdst_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - ADDR_WIDTH'(1);
                    if (rem_q == ADDR_WIDTH'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A coincident grant still completes the bus access, but the counters hold.
        if (abort_cmd && active) begin
            state_d = S_IDLE;
            wsrc_d  = wsrc_q;
            wdst_d  = wdst_q;
            rem_d   = rem_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            wsrc_q  <= '0;
            wdst_q  <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            wsrc_q  <= wsrc_d;
            wdst_q  <= wdst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
        end
    end

    assign bank_request = req;
    assign mem_addr     = (state_q == S_RD_REQ) ? wsrc_q :
                          (state_q == S_WR_REQ) ? wdst_q : '0;
    assign mem_we       = (state_q == S_WR_REQ);
    assign mem_wdata    = (state_q == S_WR_REQ) ? buf_q : '0;
    assign busy         = active;
    assign done         = done_q;

endmodule

// File: tb/tb_dma_bank_requester.sv
// Bench for dma_bank_requester: acts as arbiter and memory with random grant
// latency, then compares the observed access stream against a copy model.
module tb_dma_bank_requester;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NB = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NB-1:0] req;
    } acc_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic [NB-1:0] bank_request;
    logic [NB-1:0] bank_grant;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dma_bank_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .bank_request(bank_request), .bank_grant(bank_grant),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    // Called just after a falling edge; returns just after the next one.
    task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic program_regs(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
        cfg_write(16'hFF01, DW'(s));
        cfg_write(16'hFF02, DW'(d));
        cfg_write(16'hFF03, DW'(l));
    endtask

    // Starts a copy of l words s->d and serves it. abort_w >= 0 aborts on the
    // first WR_REQ cycle of that word; inj_k > 0 injects one cfg write that
    // many cycles after the start edge.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int l,
                            input int mind, input int maxd, input int abort_w,
                            input int inj_k, input logic [AW-1:0] inj_addr, input logic [DW-1:0] inj_data);
        acc_t          obs[$];
        logic [DW-1:0] rdv[$];
        acc_t          a;
        int k = 0, wait_tot = 0, waited = 0, dly = 0, rd_hold = 0, done_k = -1, nwr = 0;
        bit holding = 0, aborting = 0, finished = 0;
        logic [AW-1:0] h_addr = '0, ea;
        logic          h_we = 1'b0;
        logic [DW-1:0] h_data = '0, v;
        logic [NB-1:0] h_req = '0, ereq;
        int lo, hi, bidx;

        cfg_we = 1'b1; cfg_addr = 16'hFF00; cfg_wdata = 32'h1;
        @(negedge clk);
        cfg_we = 1'b0;
        while (k < 2000 && !finished) begin
            if (aborting) begin
                cfg_we = 1'b0;
                bank_grant = NB'($urandom);
                checks++;
                if (bank_request !== '0 || busy !== 1'b0)
                    $display("FAIL abort_idle: req=%b busy=%b, required req=0 busy=0", bank_request, busy);
                if (bank_request !== '0 || busy !== 1'b0) errors++;
                finished = 1;
            end else if (done === 1'b1) begin
                done_k = k;
                finished = 1;
                bank_grant = NB'($urandom);
            end else begin
                if (inj_k == k) begin
                    cfg_we = 1'b1; cfg_addr = inj_addr; cfg_wdata = inj_data;
                end else begin
                    cfg_we = 1'b0;
                end
                if (rd_hold > 0) rd_hold--;
                else mem_rdata = $urandom;
                if (bank_request !== '0) begin
                    checks++;
                    if ($countones(bank_request) != 1) begin
                        errors++;
                        $display("FAIL onehot: req=%b, required exactly one bit", bank_request);
                    end
                    if (!holding) begin
                        holding = 1; waited = 0;
                        h_addr = mem_addr; h_we = mem_we; h_data = mem_wdata; h_req = bank_request;
                        dly = $urandom_range(maxd, mind);
                        if (h_we && nwr == abort_w) begin
                            cfg_we = 1'b1; cfg_addr = 16'hFF00;
                            cfg_wdata = ($urandom_range(1, 0) == 1) ? 32'h3 : 32'h2;
                            aborting = 1;
                        end
                    end else begin
                        checks++;
                        if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_data || bank_request !== h_req) begin
                            errors++;
                            $display("FAIL stable: addr=%h we=%b wdata=%h req=%b, required addr=%h we=%b wdata=%h req=%b",
                                     mem_addr, mem_we, mem_wdata, bank_request, h_addr, h_we, h_data, h_req);
                        end
                    end
                    if (waited == dly) begin
                        bank_grant = bank_request | (NB'($urandom) & ~bank_request);
                        a.we = h_we; a.addr = h_addr; a.data = h_data; a.req = h_req;
                        obs.push_back(a);
                        holding = 0;
                        wait_tot += dly;
                        if (h_we) begin
                            nwr++;
                        end else begin
                            v = $urandom;
                            mem_rdata = v;
                            rdv.push_back(v);
                            rd_hold = 1;
                        end
                    end else begin
                        bank_grant = NB'($urandom) & ~bank_request;
                        waited++;
                    end
                end else begin
                    bank_grant = NB'($urandom);
                end
            end
            if (!finished) begin
                @(negedge clk);
                k++;
            end
        end
        cfg_we = 1'b0;
        bank_grant = '0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL timeout: no done/abort after %0d cycles, required completion", k);
            return;
        end

        if (abort_w < 0) begin
            lo = 2 * l; hi = 2 * l;
        end else begin
            lo = 2 * abort_w + 1; hi = 2 * abort_w + 2;
        end
        checks++;
        if (obs.size() < lo || obs.size() > hi) begin
            errors++;
            $display("FAIL access_count: got %0d accesses, required %0d..%0d", obs.size(), lo, hi);
        end
        foreach (obs[i]) begin
            ea   = ((obs[i].we ? d : s) + AW'(i / 2));
            bidx = int'(ea) / (65536 / NB);
            ereq = NB'(1) << bidx;
            checks++;
            if (obs[i].we !== ((i % 2) == 1) || obs[i].addr !== ea || obs[i].req !== ereq) begin
                errors++;
                $display("FAIL access[%0d]: we=%b addr=%h req=%b, required we=%b addr=%h req=%b",
                         i, obs[i].we, obs[i].addr, obs[i].req, (i % 2) == 1, ea, ereq);
            end
            if (obs[i].we && (i / 2) < rdv.size()) begin
                checks++;
                if (obs[i].data !== rdv[i / 2]) begin
                    errors++;
                    $display("FAIL wdata[%0d]: got %h, required %h", i / 2, obs[i].data, rdv[i / 2]);
                end
            end
        end

        if (abort_w < 0) begin
            checks++;
            if (done_k != 3 * l + wait_tot) begin
                errors++;
                $display("FAIL latency: done after %0d cycles, required %0d", done_k, 3 * l + wait_tot);
            end
            checks++;
            if (busy !== 1'b0 || bank_request !== '0) begin
                errors++;
                $display("FAIL done_state: busy=%b req=%b, required busy=0 req=0", busy, bank_request);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done=%b busy=%b one cycle later, required 0 0", done, busy);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                bank_grant = NB'($urandom);
                checks++;
                if (done !== 1'b0 || bank_request !== '0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL after_abort: done=%b req=%b busy=%b, required 0", done, bank_request, busy);
                end
            end
            bank_grant = '0;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bank_request, mem_addr, mem_we, mem_wdata, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_held: req=%b addr=%h we=%b wdata=%h busy=%b done=%b, required all 0",
                     bank_request, mem_addr, mem_we, mem_wdata, busy, done);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bank_request, mem_addr, mem_we, mem_wdata, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%h we=%b wdata=%h busy=%b done=%b, required all 0",
                     bank_request, mem_addr, mem_we, mem_wdata, busy, done);
        end
    endtask

    task automatic test_single_word;
        program_regs(16'h0010, 16'h4020, 16'd1);
        run_copy(16'h0010, 16'h4020, 1, 0, 0, -1, 0, '0, '0);
    endtask

    task automatic test_stalled_burst;
        program_regs(16'h1230, 16'h5670, 16'd4);
        run_copy(16'h1230, 16'h5670, 4, 2, 2, -1, 0, '0, '0);
    endtask

    task automatic test_wrap;
        program_regs(16'hFFFF, 16'hBFFF, 16'd2);
        run_copy(16'hFFFF, 16'hBFFF, 2, 0, 1, -1, 0, '0, '0);
    endtask

    task automatic test_abort;
        program_regs(16'h0100, 16'h8200, 16'd4);
        run_copy(16'h0100, 16'h8200, 4, 0, 1, 1, 0, '0, '0);
        run_copy(16'h0100, 16'h8200, 4, 0, 1, -1, 0, '0, '0);
    endtask

    task automatic test_corner;
        program_regs(16'h0000, 16'h0000, 16'd0);
        cfg_write(16'hFF00, 32'h1);
        checks++;
        if (done !== 1'b1 || bank_request !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: done=%b req=%b busy=%b, required 1 0 0", done, bank_request, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bank_request !== '0) begin
            errors++;
            $display("FAIL zero_len_after: done=%b req=%b, required 0 0", done, bank_request);
        end
        bank_grant = '1;
        repeat (2) @(negedge clk);
        checks++;
        if (bank_request !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle_grant: req=%b busy=%b done=%b, required 0", bank_request, busy, done);
        end
        bank_grant = '0;
        program_regs(16'h2000, 16'h6000, 16'd3);
        run_copy(16'h2000, 16'h6000, 3, 0, 2, -1, 4, 16'hFF00, 32'h1);
        run_copy(16'h2000, 16'h6000, 3, 0, 2, -1, 2, 16'hFF01, 32'h3333);
        run_copy(16'h2000, 16'h6000, 3, 0, 1, -1, 0, '0, '0);
    endtask

    task automatic test_random;
        logic [AW-1:0] s, d;
        int l;
        for (int n = 0; n < 6; n++) begin
            s = AW'($urandom);
            d = AW'($urandom);
            l = $urandom_range(6, 1);
            program_regs(s, d, AW'(l));
            run_copy(s, d, l, 0, 3, -1, 0, '0, '0);
        end
    endtask

    task automatic test_reset_mid;
        program_regs(16'h3000, 16'h7000, 16'd5);
        cfg_write(16'hFF00, 32'h1);
        checks++;
        if (bank_request !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_start: req=%b busy=%b, required 0001 1", bank_request, busy);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bank_request !== '0 || busy !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset: req=%b busy=%b addr=%h, required 0 0 0", bank_request, busy, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cfg_write(16'hFF00, 32'h1);
        checks++;
        if (done !== 1'b1 || bank_request !== '0) begin
            errors++;
            $display("FAIL len_cleared: done=%b req=%b, required 1 0", done, bank_request);
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        bank_grant = '0; mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_stalled_burst();
        test_wrap();
        test_abort();
        test_corner();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
